// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin bus grant controller with registered one-hot grant.
// Optional hold limit compiled in with `define BUS_ARB_HOLD_LIMIT_EN.
module bus_rr_arbiter #(
   parameter int NMASTERS = 2,
   parameter int MAX_HOLD = 16,
   parameter int IDW      = (NMASTERS > 1) ? $clog2(NMASTERS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NMASTERS-1:0] req,
   output logic [NMASTERS-1:0] gnt,
   output logic [IDW-1:0]      gnt_id,
   output logic                busy,
   output logic                expired
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   localparam logic [IDW-1:0] LAST_RST = IDW'(NMASTERS - 1);

   if (NMASTERS < 1 || NMASTERS > 16 || MAX_HOLD < 2) begin : g_bad_params
      $error("bus_rr_arbiter: illegal NMASTERS or MAX_HOLD");
   end

   state_t              r_state;
   logic [NMASTERS-1:0] r_gnt;
   logic [IDW-1:0]      r_gnt_id;
   logic [IDW-1:0]      r_last;
   logic                r_busy;

   logic                w_found_hi;
   logic                w_found_lo;
   logic [IDW-1:0]      w_win_hi;
   logic [IDW-1:0]      w_win_lo;
   logic [IDW-1:0]      w_win;
   logic [NMASTERS-1:0] w_win_oh;
   logic                w_owner_req;

   // Upward search from last+1 with wrap: prefer the lowest requester above
   // last, otherwise fall back to the lowest requester overall.
   always_comb begin
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      w_win_hi   = '0;
      w_win_lo   = '0;
      for (int i = 0; i < NMASTERS; i++) begin
         if (req[i]) begin
            if (!w_found_hi && (i > int'(r_last))) begin
               w_found_hi = 1'b1;
               w_win_hi   = IDW'(i);
            end
            if (!w_found_lo) begin
               w_found_lo = 1'b1;
               w_win_lo   = IDW'(i);
            end
         end
      end
   end

   assign w_win = w_found_hi ? w_win_hi : w_win_lo;

   always_comb begin
      w_win_oh = '0;
      for (int i = 0; i < NMASTERS; i++) begin
         w_win_oh[i] = (IDW'(i) == w_win);
      end
   end

   assign w_owner_req = |(req & r_gnt);

`ifdef BUS_ARB_HOLD_LIMIT_EN
   localparam int             HCW      = $clog2(MAX_HOLD);
   localparam logic [HCW-1:0] HOLD_TOP = HCW'(MAX_HOLD - 1);

   logic [HCW-1:0] r_hold;
   logic           r_expired;
   logic           w_others;

   assign w_others = |(req & ~r_gnt);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_last   <= LAST_RST;
         r_busy   <= 1'b0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
         r_hold    <= '0;
         r_expired <= 1'b0;
`endif
      end else begin
`ifdef BUS_ARB_HOLD_LIMIT_EN
         r_expired <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_found_lo) begin
                  r_gnt    <= w_win_oh;
                  r_gnt_id <= w_win;
                  r_last   <= w_win;
                  r_busy   <= 1'b1;
                  r_state  <= S_GRANT;
`ifdef BUS_ARB_HOLD_LIMIT_EN
                  r_hold   <= '0;
`endif
               end
            end
            S_GRANT: begin
               // Release always wins over expiry; new requests wait a turnaround cycle.
               if (!w_owner_req) begin
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
`ifdef BUS_ARB_HOLD_LIMIT_EN
               else if ((r_hold == HOLD_TOP) && w_others) begin
                  r_gnt     <= '0;
                  r_busy    <= 1'b0;
                  r_expired <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (r_hold != HOLD_TOP) begin
                  r_hold <= r_hold + HCW'(1);
               end
`endif
            end
            default: begin
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt    = r_gnt;
   assign gnt_id = r_gnt_id;
   assign busy   = r_busy;

`ifdef BUS_ARB_HOLD_LIMIT_EN
   assign expired = r_expired;
`else
   assign expired = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - scoreboard bench for bus_rr_arbiter, 4 masters, MAX_HOLD 4.
module tb_bus_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       expired;

   int n_checks = 0;
   int n_passed = 0;

   logic [3:0] q_gnt[$];
   logic [1:0] q_id[$];
   logic       q_exp[$];
   string      q_name[$];

   bus_rr_arbiter #(.NMASTERS(4), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .expired (expired)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic st(input logic [3:0] r, input logic rs, input logic [3:0] eg,
                     input logic [1:0] eid, input logic eexp, input string nm);
      @(negedge clk);
      req   = r;
      reset = rs;
      q_gnt.push_back(eg);
      q_id.push_back(eid);
      q_exp.push_back(eexp);
      q_name.push_back(nm);
   endtask

   always @(posedge clk) begin
      #1;
      if (q_gnt.size() > 0) begin
         logic [3:0] eg;
         logic [1:0] eid;
         logic       eexp;
         logic       ebusy;
         string      nm;
         eg    = q_gnt.pop_front();
         eid   = q_id.pop_front();
         eexp  = q_exp.pop_front();
         nm    = q_name.pop_front();
         ebusy = |eg;
         n_checks++;
         if (gnt !== eg || busy !== ebusy || expired !== eexp || (ebusy && gnt_id !== eid))
            $display("FAIL %s: got gnt=%b id=%0d busy=%b expired=%b, want gnt=%b id=%0d busy=%b expired=%b",
                     nm, gnt, gnt_id, busy, expired, eg, eid, ebusy, eexp);
         else
            n_passed++;
      end
   end

   initial begin
      st(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "rst_idle");
      st(4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, "rst_req");
      st(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "first_g0");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "first_rel");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "idle_stay");

      // two masters alternating, owner drops req one cycle after its grant
      st(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0, "alt_g1a");
      st(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, "alt_r1a");
      st(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "alt_g0a");
      st(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, "alt_r0a");
      st(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0, "alt_g1b");
      st(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, "alt_r1b");
      st(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "alt_g0b");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "alt_end");

      // last owner was 0; make master 1 the last owner, then 0b1010
      st(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "pre_g1");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "pre_rel");
      st(4'b1010, 1'b0, 4'b1000, 2'd3, 1'b0, "rr_g3");
      st(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, "rr_r3");
      st(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "rr_g1");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "rr_r1");
      st(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b0, "rr_g2");
      st(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, "rr_r2");
      st(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0, "rr_g3b");
      st(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, "rr_r3b");
      st(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b0, "wrap_g0");
      st(4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, "wrap_r0");
      st(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "wrap_g2");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "wrap_r2");

      // hold limit: master 0 owns, master 1 competes (last owner is 2)
      st(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "hold_g0");
`ifdef BUS_ARB_HOLD_LIMIT_EN
      for (int i = 0; i < 3; i++) st(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "hold_keep");
      st(4'b0011, 1'b0, 4'b0000, 2'd0, 1'b1, "hold_revoke");
      st(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0, "hold_next_g1");
      for (int i = 0; i < 8; i++) st(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "sat_alone");
      st(4'b0011, 1'b0, 4'b0000, 2'd0, 1'b1, "sat_revoke");
      st(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "sat_next_g0");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "sat_rel");
`else
      for (int i = 0; i < 50; i++) st(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "hold50");
      st(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, "hold_rel");
      st(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "hold_next_g1");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "hold_rel1");
`endif

      // reset during a grant to master 1
      st(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "mid_g1");
      st(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, "mid_reset");
      st(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "post_rst_g0");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "post_rst_rel");
      st(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "final_idle");

      @(posedge clk);
      #3;
      if (q_gnt.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d unchecked entries, want 0", q_gnt.size());
      end
      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin grant controller for the shared on-chip bus: takes one request line per master and returns a registered one-hot grant, so that every master gets fair access instead of lowest-index-wins priority. Sits inside the bus fabric between the masters' `req` outputs and their `gnt` inputs, and feeds the master-signal multiplexer. An optional hold limit revokes a grant that is held too long while other masters are waiting.

## Interface
- `NMASTERS`, default 2: number of requesting masters; legal range 1..16.
- `MAX_HOLD`, default 16: grant hold limit in cycles; must be ≥ 2; used only when the hold limit is compiled in.
- `IDW`, default `$clog2(NMASTERS)` with a minimum of 1: width of the grant index.
- `clk`, input, 1: bus clock; all logic is clocked on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, NMASTERS: per-master request; a master holds its bit high for the whole transaction.
- `gnt`, output, NMASTERS: registered one-hot grant; all zeros when the bus is idle.
- `gnt_id`, output, IDW: index of the current owner; only meaningful while `busy` = 1.
- `busy`, output, 1: high while any grant is active; equals the OR of all `gnt` bits.
- `expired`, output, 1: one-cycle pulse when the hold limit revokes a grant.

## Operation
- Two states:
  - IDLE: `gnt` = 0.
  - GRANT: exactly one `gnt` bit is set.
- Reset values: state = IDLE, `gnt` = 0, `gnt_id` = 0, `busy` = 0, `expired` = 0, `last` pointer = NMASTERS-1 (so master 0 wins the first arbitration), hold counter = 0.
- IDLE with any `req` bit high:
  - Winner is the first requesting index, searching upward from `last`+1 and wrapping modulo NMASTERS.
  - Load `gnt` with the winner's one-hot value, set `gnt_id` = winner and `last` = winner, clear the hold counter, go to GRANT.
- IDLE with `req` = 0: stay in IDLE; `last` is unchanged.
- GRANT, release:
  - `req[gnt_id]` sampled low → clear `gnt`, go to IDLE.
  - Requests from other masters are not evaluated in the same cycle; there is always at least one idle cycle between owners (bus turnaround).
- GRANT, hold: while the owner's `req` stays high, the grant persists; requests from other masters cannot preempt it except through the hold limit.
- Simultaneous requests from several masters in IDLE: the round-robin order alone decides the winner.
- NMASTERS = 1: the round-robin search degenerates to "grant 0 whenever `req[0]` is high"; `gnt_id` is always 0.
- Reset asserted mid-grant: everything returns to reset values on that edge, and `last` returns to NMASTERS-1.
- `req` bits are sampled once per edge and never latched; a request pulse that ends before an arbitration edge is lost.

## Timing
- Grant latency:
  - `req[i]` high at edge k with the arbiter in IDLE → `gnt[i]` visible after edge k (one cycle).
  - If a grant is active at edge k, the earliest new grant appears one cycle after that grant's release.
- Release latency: owner's `req` low at edge j → `gnt` = 0 after edge j; the next grant appears after edge j+1 at the earliest.
- `busy` and `gnt_id` change on the same edge as `gnt`.
- `expired` is high for exactly the cycle following the revoking edge, the same cycle in which `gnt` first reads 0.

## Configuration
- Macro: `BUS_ARB_HOLD_LIMIT_EN`.
- Defined:
  - The hold counter increments every cycle in GRANT and saturates at MAX_HOLD-1.
  - When the counter equals MAX_HOLD-1 and any other `req` bit is high, the arbiter clears `gnt`, pulses `expired`, and goes to IDLE.
  - The revoked owner already equals `last`, so it has lowest priority at the next arbitration.
  - With no competing request, the grant continues indefinitely and the counter stays saturated.
- Undefined: no counter is built, `expired` is tied to 0, and grants last until the owner drops `req`.

## Test plan
- Reset, then `req` = 0b01 → `gnt` = 0b01 and `gnt_id` = 0 one cycle later; all outputs read 0 during reset.
- `req` = 0b11 held, each master dropping its `req` one cycle after being granted → grant order 0, 1, 0, 1, with exactly one idle cycle between consecutive grants.
- NMASTERS = 4, `req` = 0b1010 asserted after master 1 was the last owner → master 3 is granted first, then master 1.
- With the macro defined and MAX_HOLD = 4: master 0 holds `req` while master 1 requests → `gnt` clears after 4 cycles of grant, `expired` pulses once, then `gnt` = 0b10 one cycle later. Without the macro: master 0 keeps the grant for 50 cycles and `expired` stays 0.
- Reset asserted while `gnt` = 0b10 → `gnt` = 0 on the next edge; after reset deasserts with `req` = 0b11, master 0 is granted.
